// File: rtl/bus_xfer.sv
// bus_xfer: burst transfer engine downstream of the bus grant FSM.
// Each grant moves one burst of cmd_len+1 beats from the source interface
// onto the shared bus, then reports completion (done) and an optional
// turnaround window (dly). Losing the grant mid-burst aborts with err.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   gnt               bus grant from the grant FSM
//   cmd_len           burst length minus one, sampled when the burst starts
//   src_data/src_vld  source beat; src_rdy tells the source the beat was taken
//   tgt_rdy           bus target ready
//   bus_vld/bus_data  beat presented on the bus
//   bus_last          current beat is the final beat of the burst
//   beat_cnt          index of the current beat
//   done              one-cycle pulse, burst complete
//   dly               turnaround in progress
//   err               one-cycle pulse, grant lost mid-burst
//
// Handshake: a beat transfers on a cycle where src_vld and tgt_rdy are both
// high while the engine is in XFER holding the grant; bus_vld mirrors
// src_vld and src_rdy mirrors tgt_rdy, so neither side waits on the other
// through a register.
module bus_xfer #(
    parameter int DW   = 8,
    parameter int LENW = 4,
    parameter int TURN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            gnt,
    input  logic [LENW-1:0] cmd_len,
    input  logic [DW-1:0]   src_data,
    input  logic            src_vld,
    output logic            src_rdy,
    input  logic            tgt_rdy,
    output logic            bus_vld,
    output logic [DW-1:0]   bus_data,
    output logic            bus_last,
    output logic [LENW-1:0] beat_cnt,
    output logic            done,
    output logic            dly,
    output logic            err
);

    // FSM state is kept in a named enum register so it can be observed
    // hierarchically (dut.state_q) by checkers and waveform viewers.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XFER = 3'd1,
        S_FIN  = 3'd2,
        S_TURN = 3'd3,
        S_REL  = 3'd4
    } state_t;

    // FIN already covers one turnaround cycle, so the TURN state runs for
    // TURN-1 cycles: counter loads TURN-2 and exits at zero.
    localparam logic [3:0] TURN_LOAD = (TURN > 1) ? 4'(TURN - 2) : 4'd0;
    localparam logic       TURN_NZ   = (TURN > 0);
    localparam logic       TURN_GT1  = (TURN > 1);

    state_t          state_q;
    state_t          state_d;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] cnt_q;
    logic [3:0]      turn_q;
    logic            err_q;
    logic            in_xfer;
    logic            last;
    logic            beat;

    assign in_xfer = (state_q == S_XFER);
    assign last    = (cnt_q == len_q);
    // Without the grant no beat is accepted, even if both sides are ready.
    assign beat    = in_xfer & gnt & src_vld & tgt_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (gnt) state_d = S_XFER;
            S_XFER: begin
                if (!gnt) begin
                    state_d = S_IDLE;
                end else if (beat && last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:  state_d = TURN_GT1 ? S_TURN : S_REL;
            S_TURN: if (turn_q == 4'd0) state_d = S_REL;
            // Hold here until the grant drops so one grant never yields
            // two bursts.
            S_REL:  if (!gnt) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst length, beat index, turnaround counter and abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            cnt_q  <= '0;
            turn_q <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= in_xfer & ~gnt;
            case (state_q)
                S_IDLE: begin
                    if (gnt) begin
                        len_q <= cmd_len;
                        cnt_q <= '0;
                    end
                end
                S_XFER: begin
                    if (!gnt) begin
                        cnt_q <= '0;
                    end else if (beat && !last) begin
                        // Stops at len_q, so it never wraps within a burst.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIN:  turn_q <= TURN_LOAD;
                S_TURN: if (turn_q != 4'd0) turn_q <= turn_q - 4'd1;
                default: ;
            endcase
        end
    end

    // Output decode: status from registered state, data path gated by XFER
    always_comb begin
        src_rdy  = 1'b0;
        bus_vld  = 1'b0;
        bus_data = '0;
        bus_last = 1'b0;
        beat_cnt = '0;
        done     = 1'b0;
        dly      = 1'b0;
        err      = err_q;
        case (state_q)
            S_XFER: begin
                src_rdy  = tgt_rdy & gnt;
                bus_vld  = src_vld;
                bus_data = src_data;
                bus_last = last;
                beat_cnt = cnt_q;
            end
            S_FIN: begin
                done = 1'b1;
                dly  = TURN_NZ;
            end
            S_TURN: dly = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_xfer.sv
// Testbench for bus_xfer. Two instances share all inputs: dut2 with a
// two-cycle turnaround and dut0 with no turnaround. Expected outputs come
// from burst-level rules (beat k of len, last when k==len, done one cycle
// after the final accepted beat, dly for TURN cycles) plus a data queue.
module tb_bus_xfer;
    localparam int DW   = 8;
    localparam int LENW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            gnt = 1'b0;
    logic [LENW-1:0] cmd_len = '0;
    logic [DW-1:0]   src_data = '0;
    logic            src_vld = 1'b0;
    logic            tgt_rdy = 1'b0;

    logic            s_rdy2, b_vld2, b_last2, done2, dly2, err2;
    logic [DW-1:0]   b_data2;
    logic [LENW-1:0] b_cnt2;
    logic            s_rdy0, b_vld0, b_last0, done0, dly0, err0;
    logic [DW-1:0]   b_data0;
    logic [LENW-1:0] b_cnt0;

    logic [17:0] obs2, obs0;
    assign obs2 = {b_vld2, s_rdy2, b_last2, b_cnt2, done2, dly2, err2, b_data2};
    assign obs0 = {b_vld0, s_rdy0, b_last0, b_cnt0, done0, dly0, err0, b_data0};

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    bus_xfer #(.DW(DW), .LENW(LENW), .TURN(2)) dut2 (
        .clk(clk), .rst(rst), .gnt(gnt), .cmd_len(cmd_len),
        .src_data(src_data), .src_vld(src_vld), .src_rdy(s_rdy2),
        .tgt_rdy(tgt_rdy), .bus_vld(b_vld2), .bus_data(b_data2),
        .bus_last(b_last2), .beat_cnt(b_cnt2), .done(done2), .dly(dly2),
        .err(err2)
    );

    bus_xfer #(.DW(DW), .LENW(LENW), .TURN(0)) dut0 (
        .clk(clk), .rst(rst), .gnt(gnt), .cmd_len(cmd_len),
        .src_data(src_data), .src_vld(src_vld), .src_rdy(s_rdy0),
        .tgt_rdy(tgt_rdy), .bus_vld(b_vld0), .bus_data(b_data0),
        .bus_last(b_last0), .beat_cnt(b_cnt0), .done(done0), .dly(dly0),
        .err(err0)
    );

    function automatic logic [17:0] pack(input logic v, input logic r,
                                         input logic l, input logic [3:0] c,
                                         input logic d, input logic y,
                                         input logic e, input logic [7:0] dat);
        return {v, r, l, c, d, y, e, dat};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Requests a burst from IDLE; checks the idle outputs on the way.
    task automatic idle_start(input logic [3:0] len);
        gnt      = 1'b1;
        cmd_len  = len;
        src_vld  = 1'b1;
        tgt_rdy  = 1'b1;
        src_data = 8'($urandom);
        @(negedge clk);
        n_checks++;
        if (obs2 !== 18'd0) begin n_fail++; $display("FAIL idle_t2: got %h want %h", obs2, 18'd0); end
        n_checks++;
        if (obs0 !== 18'd0) begin n_fail++; $display("FAIL idle_t0: got %h want %h", obs0, 18'd0); end
        next_cycle();
        cmd_len = 4'($urandom);  // must be ignored from here on
    endtask

    // mode 0: always ready, 1: random vld/rdy, 2: tgt_rdy every other cycle
    // with data base+k. Runs until stop beats accepted (stop<0: whole burst).
    task automatic run_beats(input int len, input int mode,
                             input logic [7:0] base, input int stop);
        int k;
        int guard;
        int target;
        logic [7:0] d;
        logic [7:0] exp_d;
        logic [17:0] e;
        k = 0;
        guard = 0;
        target = (stop < 0) ? len + 1 : stop;
        while (k < target && guard < 400) begin
            src_vld = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            tgt_rdy = (mode == 1) ? 1'($urandom_range(0, 1)) :
                      (mode == 2) ? 1'(guard % 2) : 1'b1;
            d = (mode == 2) ? base + 8'(k) : 8'($urandom);
            src_data = d;
            if (src_vld && tgt_rdy) exp_q.push_back(d);
            @(negedge clk);
            e = pack(src_vld, tgt_rdy, k == len, 4'(k), 1'b0, 1'b0, 1'b0, d);
            n_checks++;
            if (obs2 !== e) begin n_fail++; $display("FAIL beat_t2 k=%0d: got %h want %h", k, obs2, e); end
            n_checks++;
            if (obs0 !== e) begin n_fail++; $display("FAIL beat_t0 k=%0d: got %h want %h", k, obs0, e); end
            if (b_vld2 && s_rdy2) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got beat %h want none", b_data2);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (b_data2 !== exp_d) begin n_fail++; $display("FAIL sb_data: got %h want %h", b_data2, exp_d); end
                end
            end
            if (src_vld && tgt_rdy) k++;
            next_cycle();
            guard++;
        end
        n_checks++;
        if (k < target) begin n_fail++; $display("FAIL beat_budget: got %0d beats want %0d", k, target); end
        src_vld = 1'b1;
        tgt_rdy = 1'b1;
    endtask

    // Cycle c=1 is the cycle after the final beat. done on c==1, dly for
    // TURN cycles from c==1, then quiet while the grant is still held.
    task automatic tail_and_release(input int hold);
        logic [17:0] e2, e0;
        src_data = 8'($urandom);
        for (int c = 1; c <= 4 + hold; c++) begin
            @(negedge clk);
            e2 = pack(1'b0, 1'b0, 1'b0, 4'd0, c == 1, c <= 2, 1'b0, 8'd0);
            e0 = pack(1'b0, 1'b0, 1'b0, 4'd0, c == 1, 1'b0, 1'b0, 8'd0);
            n_checks++;
            if (obs2 !== e2) begin n_fail++; $display("FAIL tail_t2 c=%0d: got %h want %h", c, obs2, e2); end
            n_checks++;
            if (obs0 !== e0) begin n_fail++; $display("FAIL tail_t0 c=%0d: got %h want %h", c, obs0, e0); end
            next_cycle();
        end
        gnt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs2 !== 18'd0) begin n_fail++; $display("FAIL release_t2: got %h want %h", obs2, 18'd0); end
        next_cycle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        gnt = 1'b1;
        src_vld = 1'b1;
        tgt_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_data = 8'($urandom);
            next_cycle();
            @(negedge clk);
            n_checks++;
            if (obs2 !== 18'd0) begin n_fail++; $display("FAIL reset_t2: got %h want %h", obs2, 18'd0); end
            n_checks++;
            if (obs0 !== 18'd0) begin n_fail++; $display("FAIL reset_t0: got %h want %h", obs0, 18'd0); end
        end
        next_cycle();
        rst = 1'b0;
        gnt = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_beat();
        idle_start(4'd0);
        run_beats(0, 0, 8'h00, -1);
        tail_and_release(2);
    endtask

    task automatic test_throttled();
        idle_start(4'd3);
        run_beats(3, 2, 8'hA0, -1);
        tail_and_release(1);
    endtask

    task automatic test_turn_zero();
        idle_start(4'd1);
        run_beats(1, 1, 8'h00, -1);
        tail_and_release(5);
    endtask

    task automatic test_grant_loss();
        logic [6:0] p2, p0;
        idle_start(4'd3);
        run_beats(3, 0, 8'h00, 2);
        gnt = 1'b0;
        src_data = 8'($urandom);
        @(negedge clk);
        p2 = {s_rdy2, b_cnt2, done2, err2};
        p0 = {s_rdy0, b_cnt0, done0, err0};
        n_checks++;
        if (p2 !== {1'b0, 4'd2, 1'b0, 1'b0}) begin n_fail++; $display("FAIL drop_t2: got %h want %h", p2, {1'b0, 4'd2, 2'b00}); end
        n_checks++;
        if (p0 !== {1'b0, 4'd2, 1'b0, 1'b0}) begin n_fail++; $display("FAIL drop_t0: got %h want %h", p0, {1'b0, 4'd2, 2'b00}); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (obs2 !== pack(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd0)) begin
            n_fail++; $display("FAIL err_pulse_t2: got %h want err only", obs2);
        end
        n_checks++;
        if (obs0 !== pack(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd0)) begin
            n_fail++; $display("FAIL err_pulse_t0: got %h want err only", obs0);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (obs2 !== 18'd0) begin n_fail++; $display("FAIL err_clear: got %h want %h", obs2, 18'd0); end
        next_cycle();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        // reset in the middle of beat 2
        idle_start(4'd3);
        run_beats(3, 0, 8'h00, 2);
        src_vld = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        gnt = 1'b0;
        src_vld = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs2 !== 18'd0) begin n_fail++; $display("FAIL rst_xfer_t2 i=%0d: got %h want %h", i, obs2, 18'd0); end
            n_checks++;
            if (obs0 !== 18'd0) begin n_fail++; $display("FAIL rst_xfer_t0 i=%0d: got %h want %h", i, obs0, 18'd0); end
            next_cycle();
        end
        exp_q.delete();
        // reset during turnaround
        idle_start(4'd0);
        run_beats(0, 0, 8'h00, -1);
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (dly2 !== 1'b1) begin n_fail++; $display("FAIL turn_dly: got %b want 1", dly2); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs2 !== 18'd0) begin n_fail++; $display("FAIL rst_turn_t2 i=%0d: got %h want %h", i, obs2, 18'd0); end
            next_cycle();
        end
        exp_q.delete();
        // clean burst afterwards
        idle_start(4'd2);
        run_beats(2, 1, 8'h00, -1);
        tail_and_release(0);
    endtask

    task automatic test_max_len();
        idle_start(4'd15);
        run_beats(15, 1, 8'h00, -1);
        tail_and_release(0);
    endtask

    task automatic test_back_to_back();
        int len;
        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(0, 15);
            idle_start(4'(len));
            run_beats(len, 1, 8'h00, -1);
            tail_and_release($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_throttled();
        test_turn_zero();
        test_grant_loss();
        test_reset_mid();
        test_max_len();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_xfer.md
# bus_xfer

Bus transfer engine that sits directly downstream of the bus grant FSM. It consumes `gnt` and moves a burst of data beats from a source interface onto the shared bus. It returns the `done` and `dly` status that drives the grant FSM's busy → wait/free transitions. Each grant carries exactly one burst; a programmable turnaround holds the bus after the last beat.

## Interface
- `DW`, default 8: data width.
- `LENW`, default 4: burst-length field width; a burst is `cmd_len+1` beats, at most 2^LENW.
- `TURN`, default 2: turnaround cycles reported on `dly` after the last beat; 0..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `gnt`  in  1  bus grant from the grant FSM.
- `cmd_len`  in  LENW  beats minus one; sampled when the burst starts.
- `src_data`  in  DW  source beat data.
- `src_vld`  in  1  source beat valid.
- `src_rdy`  out  1  source beat accepted.
- `tgt_rdy`  in  1  bus target ready.
- `bus_vld`  out  1  bus beat valid.
- `bus_data`  out  DW  bus beat data.
- `bus_last`  out  1  current beat is the final beat.
- `beat_cnt`  out  LENW  index of the current beat.
- `done`  out  1  one-cycle pulse: burst complete.
- `dly`  out  1  turnaround in progress.
- `err`  out  1  one-cycle pulse: grant lost mid-burst.

## Operation
The block is a state machine with five states: IDLE, XFER, FIN, TURN, REL.

- **IDLE**
  - When `gnt`=1: latch `cmd_len` into `len_q`, clear `beat_cnt`, go to XFER.
  - Otherwise stay in IDLE.
- **XFER**
  - `bus_vld` = `src_vld`; `bus_data` = `src_data`; `src_rdy` = `tgt_rdy`. All three are combinational.
  - A beat completes when `src_vld & tgt_rdy`.
  - `bus_last` = (`beat_cnt` == `len_q`).
  - A beat with `bus_last`=0: `beat_cnt`+1.
  - A beat with `bus_last`=1: go to FIN.
  - If `gnt`=0 (grant lost): assert `err` next cycle, go to IDLE, clear `beat_cnt`. A beat presented in the same cycle is not accepted (`src_rdy` is forced to 0 when `gnt`=0).
- **FIN**
  - `done`=1 for exactly one cycle.
  - `dly` = (`TURN`>0).
  - If `TURN`>1: go to TURN and load the turnaround counter with `TURN`-2.
  - Otherwise go to REL.
- **TURN**
  - `dly`=1.
  - Decrement the counter; at 0, go to REL.
- **REL**
  - `dly`=0.
  - Wait for `gnt`=0, then go to IDLE. This guarantees one burst per grant.
- All bus/source outputs are 0 outside XFER.
- `cmd_len` changes outside IDLE-with-`gnt` are ignored.
- Counter arithmetic:
  - `beat_cnt` is LENW bits and never wraps within a burst, because it stops at `len_q`.
  - At `cmd_len`=2^LENW−1 the burst is 2^LENW beats, and `beat_cnt` ends at all-ones.

## Timing
- Reset: state=IDLE; `src_rdy`, `bus_vld`, `bus_last`, `done`, `dly`, `err` = 0; `beat_cnt`=0; `bus_data`=0. `rst` overrides everything, including mid-burst and mid-turnaround; no `done` or `err` is emitted.
- Start latency: `gnt` sampled high in IDLE at edge N → XFER from cycle N+1. The first beat can complete in cycle N+1.
- Final beat accepted at edge M → `done`=1 in cycle M+1 (FIN).
- Total cycles with `dly` high = `TURN`, starting in the FIN cycle and contiguous. `dly` is high in the same cycle as `done`, so the grant FSM goes busy→wait.
- With `TURN`=0, `done`=1 with `dly`=0, so the grant FSM goes busy→free.
- `done`, `dly`, `err`, `bus_last`, `beat_cnt` are decoded from registered state and counters only. `bus_vld`, `bus_data`, `src_rdy` are combinational passthrough, gated by state.
- `gnt` re-asserted in the cycle directly after REL→IDLE starts a new burst normally.

## Test plan
- `TURN`=2, `cmd_len`=0, `src_vld` and `tgt_rdy` held at 1, `gnt` rises at cycle 0:
  - one beat in cycle 1 with `bus_last`=1;
  - `done`=1 and `dly`=1 in cycle 2;
  - `dly`=1 in cycle 3 and 0 in cycle 4;
  - block in IDLE one cycle after `gnt` falls.
- `cmd_len`=3, `tgt_rdy` low every other cycle, data 0xA0..0xA3:
  - exactly 4 beats, in order;
  - `beat_cnt` goes 0→3;
  - `bus_last` only on 0xA3;
  - `done` 1 cycle after 0xA3.
- `TURN`=0, `cmd_len`=1: `done`=1 with `dly`=0 on every cycle; block waits in REL while `gnt` stays high.
- `gnt` dropped after 2 of 4 beats: `err`=1 for one cycle, no `done`, `beat_cnt`=0, IDLE.
- `rst` asserted during beat 2 and again during TURN: all outputs at reset values next cycle, no `done`/`err` pulse; a clean burst afterwards succeeds.
- `cmd_len`=15 (LENW=4): 16 beats; `beat_cnt` ends at 15 with `bus_last`; `done` follows; no wrap to 0 mid-burst.
